// File: rtl/muc_nbit_seq_pkg.sv
// Shared definitions for the muc multiplier family: FSM state encodings and the sign rule.
// Imported by the top and the shift-add datapath.
package muc_nbit_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A zero magnitude always carries a positive sign.
    function automatic logic sign_fix(input logic asign, input logic bsign, input logic mag_zero);
        return (asign ^ bsign) & ~mag_zero;
    endfunction

endpackage

// File: rtl/muc_shift_add_dp.sv
// Shift-add datapath: operand/accumulator registers, bit index, adder and result registers.
// Latency: one multiplier bit per step; result registers load on the step that handles bit W-1.
// Backpressure: none locally; load/step come from the controlling FSM.
module muc_shift_add_dp
    import muc_nbit_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int TRUNC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic             asign_i,
    input  logic             bsign_i,
    input  logic             approx_i,
    output logic             last_o,
    output logic [2*W-1:0]   m_o,
    output logic             sign_o
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] KEEP = ~W'((1 << TRUNC) - 1);

    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d, acc_add, m_q, m_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           sa_q, sa_d, sb_q, sb_d, sign_q, sign_d;

    assign last_o  = (idx_q == IW'(W - 1));
    assign acc_add = b_q[idx_q] ? (acc_q + ({{W{1'b0}}, a_q} << idx_q)) : acc_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        m_d    = m_q;
        sign_d = sign_q;
        if (load_i) begin
            a_d   = approx_i ? (a_i & KEEP) : a_i;
            b_d   = approx_i ? (b_i & KEEP) : b_i;
            acc_d = '0;
            idx_d = approx_i ? IW'(TRUNC) : '0;
            sa_d  = asign_i;
            sb_d  = bsign_i;
        end else if (step_i) begin
            acc_d = acc_add;
            idx_d = idx_q + 1'b1;
            // Visible result changes only when the final bit has been folded in.
            if (last_o) begin
                m_d    = acc_add;
                sign_d = sign_fix(sa_q, sb_q, acc_add == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            m_q    <= '0;
            sign_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            m_q    <= m_d;
            sign_q <= sign_d;
        end
    end

    assign m_o    = m_q;
    assign sign_o = sign_q;

endmodule

// File: rtl/muc_nbit_seq.sv
// Iterative sign-magnitude multiplier: FSM and valid/ready handshake around the shift-add datapath.
// Latency: out_valid rises W edges (W-TRUNC in approx mode) after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready returns the cycle after release.
module muc_nbit_seq
    import muc_nbit_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int TRUNC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             asign,
    input  logic             bsign,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   m,
    output logic             sign
);

    logic [1:0] state_q, state_d;
    logic       load, step, last;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign load      = in_valid & in_ready;
    assign step      = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load)      state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    muc_shift_add_dp #(.W(W), .TRUNC(TRUNC)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .a_i      (a),
        .b_i      (b),
        .asign_i  (asign),
        .bsign_i  (bsign),
        .approx_i (approx_en),
        .last_o   (last),
        .m_o      (m),
        .sign_o   (sign)
    );

endmodule

// File: tb/tb_muc_nbit_seq.sv
// Self-checking bench for muc_nbit_seq: directed cases, randomized ops against a product model,
// backpressure, mid-run reset, and a W=4 instance.
module tb_muc_nbit_seq;

    localparam int W = 8;
    localparam int T = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, asign, bsign, approx_en, out_valid, out_ready, sign;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] m;

    logic           w4_in_valid, w4_in_ready, w4_asign, w4_bsign, w4_approx_en;
    logic           w4_out_valid, w4_out_ready, w4_sign;
    logic [3:0]     w4_a, w4_b;
    logic [7:0]     w4_m;

    int n_cmp  = 0;
    int n_fail = 0;

    muc_nbit_seq #(.W(W), .TRUNC(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .asign(asign), .bsign(bsign), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .m(m), .sign(sign)
    );

    muc_nbit_seq #(.W(4), .TRUNC(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .asign(w4_asign), .bsign(w4_bsign), .approx_en(w4_approx_en),
        .out_valid(w4_out_valid), .out_ready(w4_out_ready), .m(w4_m), .sign(w4_sign)
    );

    function automatic int model_mag(input int ma, input int mb, input bit ap);
        int ta, tb_;
        ta  = ap ? (ma >> T) << T : ma;
        tb_ = ap ? (mb >> T) << T : mb;
        return ta * tb_;
    endfunction

    function automatic bit model_sign(input int mag, input bit sa, input bit sb);
        return (mag == 0) ? 1'b0 : (sa ^ sb);
    endfunction

    // Runs one operation from posedge+1 in IDLE; returns result, edges to out_valid, and post-release in_ready.
    task automatic do_op(input int oa, input int ob, input bit sa, input bit sb, input bit ap,
                         output int rm, output bit rs, output int lat, output bit rdy_after);
        in_valid  = 1'b1;
        a         = W'(oa);
        b         = W'(ob);
        asign     = sa;
        bsign     = sb;
        approx_en = ap;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        asign     = 1'($urandom);
        bsign     = 1'($urandom);
        approx_en = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rm = int'(m);
        rs = sign;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; asign = 0; bsign = 0; approx_en = 0; out_ready = 0;
        w4_in_valid = 0; w4_a = 0; w4_b = 0; w4_asign = 0; w4_bsign = 0; w4_approx_en = 0; w4_out_ready = 0;
        #2;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (m !== '0)           begin n_fail++; $display("FAIL reset_m got %0d want 0", m); end
        n_cmp++; if (sign !== 1'b0)      begin n_fail++; $display("FAIL reset_sign got %b want 0", sign); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int oa[6] = '{3, 12, 15, 0, 3, 255};
        int ob[6] = '{1, 15, 15, 77, 3, 255};
        bit sa[6] = '{1, 1, 0, 1, 1, 0};
        bit sb[6] = '{1, 0, 0, 0, 0, 0};
        bit ap[6] = '{0, 0, 1, 0, 1, 0};
        int em[6] = '{3, 180, 144, 0, 0, 16'hFE01};
        bit es[6] = '{0, 1, 0, 0, 0, 0};
        int el[6] = '{8, 8, 6, 8, 6, 8};
        int rm, lat;
        bit rs, rdy;
        for (int i = 0; i < 6; i++) begin
            do_op(oa[i], ob[i], sa[i], sb[i], ap[i], rm, rs, lat, rdy);
            n_cmp++; if (rm !== em[i])  begin n_fail++; $display("FAIL dir%0d_m got %0d want %0d", i, rm, em[i]); end
            n_cmp++; if (rs !== es[i])  begin n_fail++; $display("FAIL dir%0d_sign got %b want %b", i, rs, es[i]); end
            n_cmp++; if (lat !== el[i]) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el[i]); end
            n_cmp++; if (rdy !== 1'b1)  begin n_fail++; $display("FAIL dir%0d_in_ready_after got %b want 1", i, rdy); end
        end
    endtask

    task automatic test_w4();
        int lat;
        w4_in_valid = 1'b1; w4_a = 4'd12; w4_b = 4'd15; w4_asign = 1'b1; w4_bsign = 1'b0; w4_approx_en = 1'b0;
        @(posedge clk); #1;
        w4_in_valid = 1'b0; w4_a = 4'd1; w4_b = 4'd1;
        lat = 0;
        while (!w4_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (w4_m !== 8'hB4)  begin n_fail++; $display("FAIL w4_m got %h want b4", w4_m); end
        n_cmp++; if (w4_sign !== 1'b1) begin n_fail++; $display("FAIL w4_sign got %b want 1", w4_sign); end
        n_cmp++; if (lat !== 4)        begin n_fail++; $display("FAIL w4_latency got %0d want 4", lat); end
        w4_out_ready = 1'b1;
        @(posedge clk); #1;
        w4_out_ready = 1'b0;
        n_cmp++; if (w4_in_ready !== 1'b1) begin n_fail++; $display("FAIL w4_in_ready_after got %b want 1", w4_in_ready); end
    endtask

    task automatic test_random();
        int oa, ob, rm, lat, em;
        bit sa, sb, ap, rs, rdy;
        for (int i = 0; i < 40; i++) begin
            oa = (i % 9 == 0) ? 0 : int'($urandom_range(0, 255));
            ob = (i % 7 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            sa = 1'($urandom); sb = 1'($urandom); ap = 1'($urandom);
            em = model_mag(oa, ob, ap);
            do_op(oa, ob, sa, sb, ap, rm, rs, lat, rdy);
            n_cmp++; if (rm !== em) begin n_fail++; $display("FAIL rnd%0d_m a=%0d b=%0d ap=%b got %0d want %0d", i, oa, ob, ap, rm, em); end
            n_cmp++; if (rs !== model_sign(em, sa, sb)) begin n_fail++; $display("FAIL rnd%0d_sign got %b want %b", i, rs, model_sign(em, sa, sb)); end
            n_cmp++; if (lat !== (ap ? W - T : W)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, ap ? W - T : W); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1; a = 8'd23; b = 8'd11; asign = 1'b0; bsign = 1'b1; approx_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL bp_latency got %0d want 8", lat); end
        in_valid = 1'b1; a = 8'd99; b = 8'd98; asign = 1'b1; bsign = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (m !== 16'd253)     begin n_fail++; $display("FAIL bp%0d_m got %0d want 253", c, m); end
            n_cmp++; if (sign !== 1'b1)     begin n_fail++; $display("FAIL bp%0d_sign got %b want 1", c, sign); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid got %b want 1", c, out_valid); end
            n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp%0d_in_ready got %b want 0", c, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        repeat (10) @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_phantom_op got %b want 0", out_valid); end
        n_cmp++; if (m !== 16'd253)      begin n_fail++; $display("FAIL bp_idle_hold_m got %0d want 253", m); end
    endtask

    task automatic test_reset_mid_run();
        int rm, lat;
        bit rs, rdy;
        in_valid = 1'b1; a = 8'd200; b = 8'd201; asign = 1'b1; bsign = 1'b0; approx_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (m !== '0)           begin n_fail++; $display("FAIL midrst_m got %0d want 0", m); end
        n_cmp++; if (sign !== 1'b0)      begin n_fail++; $display("FAIL midrst_sign got %b want 0", sign); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_op(5, 6, 0, 0, 0, rm, rs, lat, rdy);
        n_cmp++; if (rm !== 30)  begin n_fail++; $display("FAIL midrst_after_m got %0d want 30", rm); end
        n_cmp++; if (rs !== 1'b0) begin n_fail++; $display("FAIL midrst_after_sign got %b want 0", rs); end
        n_cmp++; if (lat !== 8)  begin n_fail++; $display("FAIL midrst_after_latency got %0d want 8", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_w4();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
